// File: rtl/sar_pkg.sv
// sar_pkg -- shared definitions for the SAR conversion controller.
//   sar_state_e : controller state encoding (IDLE, SAMPLE, CONV, DONE)
//   DIV_MIN     : smallest legal clk-cycles-per-bit-period
//   NBITS_MIN / NBITS_MAX : legal conversion resolution range
//   max2()      : constant helper for sizing counters
package sar_pkg;

  localparam int DIV_MIN   = 4;
  localparam int NBITS_MIN = 2;
  localparam int NBITS_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_DONE
  } sar_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// sar_cmp_sync -- brings the asynchronous comparator outputs into the clk
// domain and forms the keep/clear decision for the current trial bit.
//   clk, rst : clock and synchronous active-high reset
//   vcp, vcn : raw comparator outputs (asynchronous)
//   keep     : 1 when the synchronised comparator says vin >= trial code
module sar_cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic vcp,
  input  logic vcn,
  output logic keep
);

  logic [1:0] sync_p;
  logic [1:0] sync_n;

  // NOTE: non-blocking assignments so each flop samples the previous stage's
  // old value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= '0;
      sync_n <= '0;
    end else begin
      sync_p <= {sync_p[0], vcp};
      sync_n <= {sync_n[0], vcn};
    end
  end

  // Only a clean vcp=1/vcn=0 keeps the bit; an unresolved comparator
  // (both equal) is treated as "below" so the code errs low.
  assign keep = sync_p[1] & ~sync_n[1];

endmodule

// File: rtl/sar_ctrl_n.sv
// sar_ctrl_n -- successive-approximation ADC controller.
//   Parameters: NBITS (resolution), DIV (clk cycles per bit period, even),
//               SAMP_CYC (sampling phase length in bit periods).
//   Inputs : clk, rst (sync, active-high), en, mode (0 single / 1 continuous),
//            start (single-shot trigger), vcp/vcn (async comparator).
//   Outputs: samp (sampling switch), clk_comp (comparator strobe),
//            dac_ctrl (trial code), dout (last result), dout_valid (1-cycle
//            pulse on dout update), busy, overrun (sticky dropped start).
module sar_ctrl_n
  import sar_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int DIV      = 4,
  parameter int SAMP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             vcp,
  input  logic             vcn,
  output logic             samp,
  output logic             clk_comp,
  output logic [NBITS-1:0] dac_ctrl,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun
);

  if (NBITS < NBITS_MIN || NBITS > NBITS_MAX) begin : g_bad_nbits
    $error("sar_ctrl_n: NBITS out of range");
  end
  if (DIV < DIV_MIN || (DIV % 2) != 0) begin : g_bad_div
    $error("sar_ctrl_n: DIV must be even and >= DIV_MIN");
  end
  if (SAMP_CYC < 1) begin : g_bad_samp
    $error("sar_ctrl_n: SAMP_CYC must be >= 1");
  end

  localparam int CW = $clog2(DIV);
  localparam int PW = $clog2(max2(SAMP_CYC, NBITS));
  localparam int IW = $clog2(NBITS);

  localparam logic [CW-1:0]    CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]    CNT_HALF  = CW'(DIV / 2);
  localparam logic [PW-1:0]    SAMP_LAST = PW'(SAMP_CYC - 1);
  localparam logic [PW-1:0]    CONV_LAST = PW'(NBITS - 1);
  localparam logic [NBITS-1:0] MIDSCALE  = {1'b1, {(NBITS-1){1'b0}}};

  sar_state_e       state;
  sar_state_e       state_nxt;
  logic [CW-1:0]    cnt;       // position inside the current bit period
  logic [PW-1:0]    per_cnt;   // bit periods elapsed in SAMPLE / CONV
  logic [IW-1:0]    bit_idx;   // trial bit under decision in CONV
  logic [NBITS-1:0] dac_dec;   // trial code after this period's decision
  logic             keep;
  logic             period_end;

  sar_cmp_sync u_cmp_sync (
    .clk  (clk),
    .rst  (rst),
    .vcp  (vcp),
    .vcn  (vcn),
    .keep (keep)
  );

  assign period_end = (cnt == CNT_LAST);

  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (en && (mode || start)) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (!en) state_nxt = ST_IDLE;
                 else if (period_end && per_cnt == SAMP_LAST) state_nxt = ST_CONV;
      ST_CONV:   if (!en) state_nxt = ST_IDLE;
                 else if (period_end && per_cnt == CONV_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = (en && mode) ? ST_SAMPLE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Resolve bit k and raise bit k-1 in the same edge, so the next trial
  // code is on the DAC from the first cycle of the following bit period.
  always_comb begin
    bit_idx          = IW'(NBITS - 1) - IW'(per_cnt);
    dac_dec          = dac_ctrl;
    dac_dec[bit_idx] = keep;
    if (bit_idx != '0) dac_dec[bit_idx - IW'(1)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      per_cnt  <= '0;
      dac_ctrl <= '0;
      dout     <= '0;
      overrun  <= 1'b0;
    end else begin
      if (start && !mode && state != ST_IDLE) overrun <= 1'b1;

      // Counters restart on every state change so each phase starts aligned.
      if (state_nxt != state || state_nxt == ST_IDLE) begin
        cnt     <= '0;
        per_cnt <= '0;
      end else if (period_end) begin
        cnt     <= '0;
        per_cnt <= per_cnt + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state_nxt)
        ST_IDLE:   dac_ctrl <= '0;
        ST_SAMPLE: dac_ctrl <= MIDSCALE;
        default:   if (state == ST_CONV && period_end) dac_ctrl <= dac_dec;
      endcase

      if (state == ST_CONV && state_nxt == ST_DONE) dout <= dac_dec;
    end
  end

  assign samp       = (state == ST_SAMPLE);
  assign busy       = (state != ST_IDLE);
  assign dout_valid = (state == ST_DONE);
  assign clk_comp   = (state == ST_CONV) && (cnt < CNT_HALF);

endmodule
